// File: rtl/fp_pkg.sv
// Shared float-format helpers and FSM state type for the unscale block and its adder.
package fp_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  function automatic int unsigned exp_bits(input bit is_half);
    return is_half ? 5 : 8;
  endfunction

  function automatic int unsigned mant_bits(input int unsigned bits, input bit is_half);
    return bits - 1 - exp_bits(is_half);
  endfunction

  function automatic logic [7:0] get_exp(input logic [31:0] w, input int unsigned mb,
                                         input int unsigned eb);
    return 8'((w >> mb) & ((32'd1 << eb) - 32'd1));
  endfunction

  function automatic logic [31:0] set_exp(input logic [31:0] w, input logic [7:0] e,
                                          input int unsigned mb, input int unsigned eb);
    logic [31:0] mask;
    mask = ((32'd1 << eb) - 32'd1) << mb;
    return (w & ~mask) | ((32'(e) << mb) & mask);
  endfunction

endpackage

// File: rtl/add.sv
// Two-stage float adder for same-sign operands, round-to-nearest-even; zero operands flush.
module add
  import fp_pkg::*;
#(
  parameter int unsigned BITS      = 16,
  parameter string       PRECISION = "HALF"
) (
  input  logic            rstn,
  input  logic            clk,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  output logic [BITS-1:0] c
);
  localparam bit          IsHalf = (PRECISION == "HALF");
  localparam int unsigned EB     = exp_bits(IsHalf);
  localparam int unsigned MB     = mant_bits(BITS, IsHalf);
  localparam int unsigned MW     = MB + 1;
  localparam int unsigned W      = 2 * MW + 2;
  localparam logic [EB-1:0] ExpMax = '1;

  logic            v_q;
  logic [BITS-1:0] x_q, y_q;  // x holds the larger magnitude
  logic [EB-1:0]   ex, ey;
  logic [W-1:0]    mx, my, my_full;
  logic [W:0]      s, sn;
  logic [MW-1:0]   m;
  logic [MW:0]     mr;
  logic            lost, g, st, rnd;
  logic [MB-1:0]   frac;
  int              d, er_i;
  logic [BITS-1:0] sum;
  logic [1:0]      unused_bits;

  assign unused_bits = {y_q[BITS-1], mr[MB]};

  always_comb begin
    ex      = x_q[BITS-2 -: EB];
    ey      = y_q[BITS-2 -: EB];
    d       = int'(ex) - int'(ey);
    mx      = {1'b1, x_q[MB-1:0], {(MW + 2){1'b0}}};
    my_full = {1'b1, y_q[MB-1:0], {(MW + 2){1'b0}}};
    my      = '0;
    lost    = 1'b1;
    if (d < int'(W)) begin
      my   = my_full >> d;
      lost = |(my_full & ~({W{1'b1}} << d));
    end
    s    = {1'b0, mx} + {1'b0, my};
    sn   = s[W] ? s : (s << 1);
    m    = sn[W -: MW];
    g    = sn[W-MW];
    st   = (|sn[W-MW-1:0]) | lost;
    rnd  = g & (st | m[0]);
    mr   = {1'b0, m} + {{MW{1'b0}}, rnd};
    frac = mr[MW] ? {MB{1'b0}} : mr[MB-1:0];
    er_i = int'(ex) + (s[W] ? 1 : 0) + (mr[MW] ? 1 : 0);
    if (ex == ExpMax || ey == '0) begin
      sum = x_q;
    end else if (er_i >= int'(ExpMax)) begin
      sum = {x_q[BITS-1], ExpMax, {MB{1'b0}}};
    end else begin
      sum = {x_q[BITS-1], er_i[EB-1:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q       <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      v_q       <= in_valid;
      out_valid <= v_q;
      if (in_valid) begin
        x_q <= (a[BITS-2:0] >= b[BITS-2:0]) ? a : b;
        y_q <= (a[BITS-2:0] >= b[BITS-2:0]) ? b : a;
      end
      if (v_q) c <= sum;
    end
  end

endmodule

// File: rtl/unscale.sv
// c = a * 4/3 via the series 1 + 1/4 + 1/16 + ..., accumulated through one shared adder.
module unscale
  import fp_pkg::*;
#(
  parameter int unsigned BITS      = 16,
  parameter string       PRECISION = "HALF",
  parameter int unsigned TERMS     = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  output logic            out_valid,
  output logic [BITS-1:0] c
);
  localparam bit          IsHalf = (PRECISION == "HALF");
  localparam int unsigned EB     = exp_bits(IsHalf);
  localparam int unsigned MB     = mant_bits(BITS, IsHalf);
  localparam logic [7:0]  ExpMax = 8'((1 << EB) - 1);

  state_e          state;
  logic [BITS-1:0] a_r, acc, add_b, add_c;
  logic [7:0]      k, exp_in, exp_a;
  logic            add_go, add_done;

  // Term k is a with its exponent lowered by 2k, i.e. a / 4^k.
  function automatic logic [BITS-1:0] term(input logic [BITS-1:0] w, input logic [7:0] kk);
    logic [7:0] e;
    e = get_exp(32'(w), MB, EB);
    return BITS'(set_exp(32'(w), e - {kk[6:0], 1'b0}, MB, EB));
  endfunction

  assign exp_in   = get_exp(32'(a), MB, EB);
  assign exp_a    = get_exp(32'(a_r), MB, EB);
  assign in_ready = (state == StIdle);
  assign add_go   = (state == StIssue);
  assign add_b    = term(a_r, k);

  add #(
    .BITS      (BITS),
    .PRECISION (PRECISION)
  ) add1 (
    .rstn      (rstn),
    .clk       (clk),
    .in_valid  (add_go),
    .a         (acc),
    .b         (add_b),
    .out_valid (add_done),
    .c         (add_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      a_r       <= '0;
      acc       <= '0;
      k         <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            a_r <= a;
            acc <= a;
            k   <= 8'd1;
            if (exp_in == 8'd0 || exp_in == ExpMax || exp_in <= 8'd2) state <= StDone;
            else state <= StIssue;
          end
        end
        StIssue: state <= StWait;
        StWait: begin
          if (add_done) begin
            acc <= add_c;
            k   <= k + 8'd1;
            // Stop once the next term's exponent would reach zero.
            if (k == 8'(TERMS) || {1'b0, exp_a} <= ({k, 1'b0} + 9'd2)) state <= StDone;
            else state <= StIssue;
          end
        end
        StDone: begin
          c         <= acc;
          out_valid <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unscale.sv
// Bench for unscale: fixed vectors, back-to-back, mid-operation reset and random words.
module tb_unscale;
  import fp_pkg::*;

  localparam int TERMS = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic        out_valid;
  logic [15:0] c;

  int errors = 0;
  int checks = 0;
  int add_ops = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] c;
    int          ops;
  } vec_t;

  unscale #(
    .BITS      (16),
    .PRECISION ("HALF"),
    .TERMS     (TERMS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .c         (c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rstn && dut.add1.in_valid) add_ops++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real v;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    for (int i = 0; i < int'(h[14:10]); i++) v = v * 2.0;
    for (int i = 0; i < 15; i++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    int   e, n;
    real  scaled, rem;
    s = (x < 0.0);
    if (s) x = -x;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    scaled = x * 1024.0;
    n = int'($floor(scaled));
    rem = scaled - real'(n);
    if (rem > 0.5 || (rem == 0.5 && (n % 2) == 1)) n++;
    if (n == 2048) begin n = 1024; e++; end
    if (e + 15 >= 31) return {s, 5'h1f, 10'h000};
    return {s, 5'(e + 15), 10'(n - 1024)};
  endfunction

  // a*4/3 as a rounded running sum of a/4^k, stopping before a term's exponent hits zero.
  task automatic model(input logic [15:0] av, output logic [15:0] cv, output int ops);
    int  e;
    real scale;
    e = int'(av[14:10]);
    cv = av;
    ops = 0;
    if (e == 0 || e == 31 || e <= 2) return;
    ops = (e - 1) / 2;
    if (ops > TERMS) ops = TERMS;
    scale = 1.0;
    for (int k = 1; k <= ops; k++) begin
      scale = scale / 4.0;
      cv = r2h(h2r(cv) + h2r(av) * scale);
    end
  endtask

  task automatic run_word(input string name, input logic [15:0] av, input logic [15:0] ec,
                          input int eops);
    int cyc, ops0;
    cyc = 0;
    while (!in_ready && cyc < 1000) begin @(negedge clk); cyc++; end
    in_valid = 1'b1;
    a = av;
    ops0 = add_ops;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 1000) begin @(negedge clk); cyc++; end
    check({name, " done"}, 32'(out_valid), 32'd1);
    check({name, " c"}, 32'(c), 32'(ec));
    check({name, " add ops"}, 32'(add_ops - ops0), 32'(eops));
    if (eops == 0) check({name, " latency"}, 32'(cyc), 32'd2);
    @(negedge clk);
    check({name, " pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] rc, ra;
    int          rops, cyc;
    bit          busy_ok;

    vecs[0] = '{16'h3C00, 16'h3D55, 6};
    vecs[1] = '{16'hC000, 16'hC155, 6};
    vecs[2] = '{16'h0000, 16'h0000, 0};
    vecs[3] = '{16'h7C00, 16'h7C00, 0};
    vecs[4] = '{16'h0800, 16'h0800, 0};
    vecs[5] = '{16'h1000, 16'h1100, 1};
    vecs[6] = '{16'h8000, 16'h8000, 0};

    #12;
    check("reset c", 32'(c), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_word($sformatf("vec%0d", i), vecs[i].a, vecs[i].c, vecs[i].ops);

    // Back-to-back: in_valid held, second word waits for the first result.
    in_valid = 1'b1;
    a = 16'h3C00;
    @(negedge clk);
    a = 16'hC000;
    busy_ok = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 1000) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b busy", 32'(busy_ok), 32'd1);
    check("b2b first c", 32'(c), 32'h3D55);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 1000) begin @(negedge clk); cyc++; end
    check("b2b second done", 32'(out_valid), 32'd1);
    check("b2b second c", 32'(c), 32'hC155);
    @(negedge clk);

    // Reset while an add is in flight.
    in_valid = 1'b1;
    a = 16'h3C00;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (dut.state != StWait && cyc < 100) begin @(negedge clk); cyc++; end
    check("reached wait", 32'(dut.state == StWait), 32'd1);
    rstn = 1'b0;
    #1;
    check("abort c", 32'(c), 32'h0);
    check("abort out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) busy_ok = 1'b0;
    end
    check("no pulse after abort", 32'(busy_ok), 32'd1);
    run_word("after abort", 16'h3C00, 16'h3D55, 6);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ra[14:10] = 5'($urandom_range(1, 29));
      model(ra, rc, rops);
      run_word($sformatf("rand %h", ra), ra, rc, rops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
